i2s_tx_ctrl: RTL and testbench

Sequencing and source-arbitration controller for the I2S transmit path. It generates the `mclk_en`/`sclk_en` strobes and the local reset for the I2S master, and starts and stops the master on frame boundaries. It also arbitrates between two 48-bit stereo sample sources (bus FIFO and tone generator) and feeds the master's valid/ready sample port, substituting samples on underrun and counting underruns.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/clk_en_gen.sv | 53 +++++
 rtl/i2s_tx_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit controller:
//   state_t        - sequencing FSM states (IDLE, START, RUN, STOP)
//   SAMPLE_W       - width of one stereo sample (two 24-bit channels)
//   FRAME_STROBES  - sclk_en strobes per frame (64 SCLK periods x 2 edges)
//   FRAME_W        - width of the frame strobe counter
// ----------------------------------------------------------------------------
package i2s_pkg;

    localparam int SAMPLE_W      = 48;
    localparam int FRAME_STROBES = 128;
    localparam int FRAME_W       = $clog2(FRAME_STROBES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/clk_en_gen.sv
// ----------------------------------------------------------------------------
// clk_en_gen
// Pair of free-running dividers producing one-cycle strobe enables.
// Both counters are held at zero while clear is high and start counting
// together on the first cycle clear is low, so the first pulse of each
// strobe falls on cycle DIV-1 after clear drops.
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  synchronous hold-at-zero; also masks both strobes
//   mclk_en  out 1-cycle pulse every MCLK_DIV cycles
//   sclk_en  out 1-cycle pulse every SCLK_DIV cycles
//
// MCLK_DIV and SCLK_DIV must both be >= 2.
// ----------------------------------------------------------------------------
module clk_en_gen #(
    parameter int MCLK_DIV = 4,
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic mclk_en,
    output logic sclk_en
);

    localparam int MW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int SW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCLK_DIV - 1);

    logic [MW-1:0] mclk_cnt;
    logic [SW-1:0] sclk_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mclk_cnt <= '0;
            sclk_cnt <= '0;
        end else begin
            mclk_cnt <= (mclk_cnt == M_LAST) ? '0 : mclk_cnt + MW'(1);
            sclk_cnt <= (sclk_cnt == S_LAST) ? '0 : sclk_cnt + SW'(1);
        end
    end

    // Masking with clear keeps the strobes low in the very cycle the
    // controller leaves RUN/STOP, even though the counters are only zeroed
    // on the following edge.
    assign mclk_en = !clear && (mclk_cnt == M_LAST);
    assign sclk_en = !clear && (sclk_cnt == S_LAST);

endmodule

// File: rtl/i2s_tx_ctrl.sv
// ----------------------------------------------------------------------------
// i2s_tx_ctrl
// Sequencing and source arbitration for the I2S transmit path.
//   - Holds the I2S master in reset while idle, releases it after a
//     two-cycle START, and only stops it at the end of a full frame.
//   - Generates mclk_en / sclk_en strobes through clk_en_gen.
//   - Buffers one stereo sample from the selected source and delivers it
//     on the master's out_ready pulse; on underrun it substitutes either
//     the last delivered sample or zero and counts the event.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cfg_enable          1 = run, 0 = stop at the next frame boundary
//   cfg_src             source select used at each buffer load
//   cfg_mute            force out_data to zero (sources still consumed)
//   cfg_hold_last       underrun fill: 1 = last sample, 0 = zero
//   cnt_clr             clears underrun_cnt (wins over an increment)
//   src0_*/src1_*       48-bit sample sources (valid/ready)
//   i2s_rst             reset to the I2S master
//   mclk_en, sclk_en    strobe enables to the master
//   out_data/valid/ready sample port to the master
//   busy                high in START, RUN and STOP
//   underrun_cnt        saturating underrun count
//   fsm_state           current FSM state, for observation
//
// Handshake semantics: a source transfer happens in a cycle where both
// srcN_valid and srcN_ready are high. srcN_ready is a combinational
// one-cycle pulse that may depend on srcN_valid; the source must not make
// valid depend on ready. On the output side out_valid is a level that is
// high whenever the master may take a sample, and out_ready is a one-cycle
// pulse; out_data is combinational so it is valid in that same cycle.
// ----------------------------------------------------------------------------
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV = 4,
    parameter int SCLK_DIV = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic                cfg_src,
    input  logic                cfg_mute,
    input  logic                cfg_hold_last,
    input  logic                cnt_clr,
    input  logic [SAMPLE_W-1:0] src0_data,
    input  logic                src0_valid,
    output logic                src0_ready,
    input  logic [SAMPLE_W-1:0] src1_data,
    input  logic                src1_valid,
    output logic                src1_ready,
    output logic                i2s_rst,
    output logic                mclk_en,
    output logic                sclk_en,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    underrun_cnt,
    output state_t              fsm_state
);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_STROBES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;

    logic               start_cnt;   // 0 on first START cycle, 1 on second
    logic [FRAME_W-1:0] frame_cnt;   // index of the next sclk_en in the frame
    logic               active;      // RUN or STOP: strobes and samples flow
    logic               frame_end;   // this sclk_en closes the frame

    assign frame_end = sclk_en && (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        i2s_rst    = 1'b1;
        busy       = 1'b0;
        active     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                busy = 1'b1;
                if (start_cnt) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                active  = 1'b1;
                i2s_rst = 1'b0;
                if (!cfg_enable) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // cfg_enable is deliberately ignored here: a stop always
                // runs to the frame boundary and restarts through IDLE.
                busy    = 1'b1;
                active  = 1'b1;
                i2s_rst = 1'b0;
                if (frame_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fsm_state = state;
    assign out_valid = active;

    always_ff @(posedge clk) begin
        if (rst || (state != ST_START)) begin
            start_cnt <= 1'b0;
        end else begin
            start_cnt <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Strobe generation and frame position
    // ------------------------------------------------------------------
    clk_en_gen #(
        .MCLK_DIV (MCLK_DIV),
        .SCLK_DIV (SCLK_DIV)
    ) u_clk_en_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (!active),
        .mclk_en (mclk_en),
        .sclk_en (sclk_en)
    );

    // 7-bit counter wraps 127 -> 0 on its own; it is held at zero
    // whenever the strobes are not running.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            frame_cnt <= '0;
        end else if (sclk_en) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer, source arbitration and delivery
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] sample_buf;
    logic [SAMPLE_W-1:0] last_sample;
    logic                full;

    logic                sel_valid;
    logic [SAMPLE_W-1:0] sel_data;
    logic                deliver;
    logic                load;
    logic                underrun;

    assign sel_valid = cfg_src ? src1_valid : src0_valid;
    assign sel_data  = cfg_src ? src1_data  : src0_data;

    assign deliver  = active && out_ready;
    // A delivery in the same cycle sees the old (empty) buffer, so the
    // load waits one cycle rather than racing the delivery.
    assign load     = active && !full && sel_valid && !out_ready;
    assign underrun = deliver && !full;

    assign src0_ready = load && !cfg_src;
    assign src1_ready = load &&  cfg_src;

    always_ff @(posedge clk) begin
        if (rst || (state == ST_START)) begin
            sample_buf  <= '0;
            last_sample <= '0;
            full        <= 1'b0;
        end else if (load) begin
            sample_buf <= sel_data;
            full       <= 1'b1;
        end else if (deliver && full) begin
            full        <= 1'b0;
            last_sample <= sample_buf;
        end
    end

    // Mute only masks the port value; buffer and last_sample bookkeeping
    // carry on exactly as if the sample had been sent.
    always_comb begin
        out_data = '0;
        if (active && !cfg_mute) begin
            if (full) begin
                out_data = sample_buf;
            end else if (cfg_hold_last) begin
                out_data = last_sample;
            end
        end
    end

    // ------------------------------------------------------------------
    // Underrun counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != CNT_MAX)) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
module tb_i2s_tx_ctrl;
    import i2s_pkg::*;

    localparam int MCLK_DIV = 4;
    localparam int SCLK_DIV = 16;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 4;
    localparam logic [47:0] W_UNDER = 48'hABCDEF_123456;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cfg_enable = 1'b0;
    logic              cfg_src = 1'b0;
    logic              cfg_mute = 1'b0;
    logic              cfg_hold_last = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [47:0]       src0_data = '0;
    logic              src0_valid = 1'b0;
    logic              src0_ready;
    logic [47:0]       src1_data = '0;
    logic              src1_valid = 1'b0;
    logic              src1_ready;
    logic              i2s_rst, mclk_en, sclk_en, out_valid, busy;
    logic [47:0]       out_data;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  underrun_cnt;
    state_t            fsm_state;

    logic              s_src0_ready, s_src1_ready, s_i2s_rst, s_mclk_en, s_sclk_en;
    logic              s_out_valid, s_busy;
    logic [47:0]       s_out_data;
    logic [SAT_W-1:0]  s_underrun_cnt;
    state_t            s_fsm_state;

    i2s_tx_ctrl #(.MCLK_DIV(MCLK_DIV), .SCLK_DIV(SCLK_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_src(cfg_src),
        .cfg_mute(cfg_mute), .cfg_hold_last(cfg_hold_last), .cnt_clr(cnt_clr),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .i2s_rst(i2s_rst), .mclk_en(mclk_en), .sclk_en(sclk_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .underrun_cnt(underrun_cnt), .fsm_state(fsm_state)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    i2s_tx_ctrl #(.MCLK_DIV(MCLK_DIV), .SCLK_DIV(SCLK_DIV), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_src(cfg_src),
        .cfg_mute(cfg_mute), .cfg_hold_last(cfg_hold_last), .cnt_clr(cnt_clr),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(s_src0_ready),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(s_src1_ready),
        .i2s_rst(s_i2s_rst), .mclk_en(s_mclk_en), .sclk_en(s_sclk_en),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .busy(s_busy), .underrun_cnt(s_underrun_cnt), .fsm_state(s_fsm_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    logic [47:0] mdl_q[$];      // samples accepted but not yet delivered
    logic [47:0] mdl_last = '0; // last sample taken from the buffer
    int          mdl_under = 0; // underruns since last clear
    logic [47:0] exp_q[$];      // expected out_data per out_ready pulse
    logic [47:0] got_q[$];      // observed out_data per out_ready pulse
    logic [47:0] feed0[$];
    logic [47:0] feed1[$];

    int wrong_ready = 0;
    int acc0_n = 0, acc1_n = 0;
    int cyc = 0, sclk_n = 0, mclk_n = 0, last_sclk_cyc = 0;
    logic o_rst, o_mclk, o_sclk, o_busy;

    function automatic logic [47:0] rnd48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    // One clock: observe at negedge, update the model, then drive the
    // sources just after the rising edge.
    task automatic tick();
        logic a0, a1;
        logic [47:0] w, e;
        @(negedge clk);
        cyc++;
        o_rst = i2s_rst; o_mclk = mclk_en; o_sclk = sclk_en; o_busy = busy;
        if (mclk_en) mclk_n++;
        if (sclk_en) begin sclk_n++; last_sclk_cyc = cyc; end
        a0 = !rst && src0_ready && src0_valid;
        a1 = !rst && src1_ready && src1_valid;
        if (rst) begin
            mdl_q.delete(); mdl_last = '0; mdl_under = 0;
        end else begin
            if (out_ready) begin
                if (mdl_q.size() > 0) begin
                    w = mdl_q.pop_front();
                    mdl_last = w;
                    e = cfg_mute ? '0 : w;
                end else begin
                    e = (cfg_mute || !cfg_hold_last) ? '0 : mdl_last;
                    mdl_under++;
                end
                exp_q.push_back(e);
                got_q.push_back(out_data);
            end
            if (cnt_clr) mdl_under = 0;
            // one-entry buffer: no take while occupied or during a delivery
            if ((a0 || a1) && (out_ready || mdl_q.size() > 0)) wrong_ready++;
            if (src0_ready && cfg_src) wrong_ready++;
            if (src1_ready && !cfg_src) wrong_ready++;
            if (a0) begin mdl_q.push_back(src0_data); acc0_n++; end
            if (a1) begin mdl_q.push_back(src1_data); acc1_n++; end
        end
        @(posedge clk);
        #1;
        if (a0) void'(feed0.pop_front());
        if (a1) void'(feed1.pop_front());
        src0_valid = (feed0.size() > 0);
        src0_data  = src0_valid ? feed0[0] : rnd48();
        src1_valid = (feed1.size() > 0);
        src1_data  = src1_valid ? feed1[0] : rnd48();
    endtask

    task automatic pulse_ready(input int gap);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic start_run();
        int n;
        n = 0;
        mdl_q.delete();
        mdl_last = '0;
        got_q.delete();
        exp_q.delete();
        cfg_enable = 1'b1;
        do begin tick(); n++; end while (o_rst && n < 10);
        checks++;
        if (o_rst !== 1'b0) begin
            errors++;
            $display("FAIL start_release: i2s_rst=%b after %0d cycles, required 0", o_rst, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        feed0.push_back(rnd48());
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (i2s_rst !== 1'b1) begin errors++; $display("FAIL reset_i2s_rst: got %b want 1", i2s_rst); end
        checks++; if (mclk_en !== 1'b0 || sclk_en !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", mclk_en, sclk_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b%b want 00", src0_ready, src1_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_data !== 48'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (underrun_cnt !== '0) begin errors++; $display("FAIL reset_underrun_cnt: got %0d want 0", underrun_cnt); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        feed0.delete();
        tick();
    endtask

    task automatic test_divider();
        int bad_rst, bad_busy, bad_m, bad_s;
        logic em, es;
        bad_rst = 0; bad_busy = 0; bad_m = 0; bad_s = 0;
        sclk_n = 0; mclk_n = 0;
        cfg_enable = 1'b1;
        for (int t = 0; t < 300; t++) begin
            tick();
            em = (t >= 3) && (((t - 3) % MCLK_DIV) == MCLK_DIV - 1);
            es = (t >= 3) && (((t - 3) % SCLK_DIV) == SCLK_DIV - 1);
            if (o_rst !== (t < 3)) bad_rst++;
            if (o_busy !== (t >= 1)) bad_busy++;
            if (o_mclk !== em) bad_m++;
            if (o_sclk !== es) bad_s++;
        end
        checks++; if (bad_rst != 0) begin errors++; $display("FAIL div_i2s_rst_timing: %0d bad cycles, want 0", bad_rst); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL div_busy_timing: %0d bad cycles, want 0", bad_busy); end
        checks++; if (bad_m != 0) begin errors++; $display("FAIL div_mclk_en: %0d bad cycles, want 0", bad_m); end
        checks++; if (bad_s != 0) begin errors++; $display("FAIL div_sclk_en: %0d bad cycles, want 0", bad_s); end
        checks++; if (mclk_n != (300 - 3) / MCLK_DIV) begin errors++; $display("FAIL div_mclk_count: got %0d want %0d", mclk_n, (300 - 3) / MCLK_DIV); end
        checks++; if (sclk_n != (300 - 3) / SCLK_DIV) begin errors++; $display("FAIL div_sclk_count: got %0d want %0d", sclk_n, (300 - 3) / SCLK_DIV); end
    endtask

    // Continues the run from test_divider; drops enable at strobe 40 of
    // the second frame, so exactly two full frames must be issued.
    task automatic test_stop();
        int n, rise_cyc;
        n = 0;
        while (sclk_n < FRAME_STROBES + 41 && n < 6000) begin tick(); n++; end
        checks++; if (sclk_n != FRAME_STROBES + 41) begin errors++; $display("FAIL stop_reach_strobe40: got %0d strobes want %0d", sclk_n, FRAME_STROBES + 41); end
        cfg_enable = 1'b0;
        repeat (20) tick();
        cfg_enable = 1'b1;          // must not cut the stop short
        repeat (5) tick();
        cfg_enable = 1'b0;
        n = 0;
        while (!o_rst && n < 3000) begin tick(); n++; end
        rise_cyc = cyc;
        checks++; if (o_rst !== 1'b1) begin errors++; $display("FAIL stop_timeout: i2s_rst=%b want 1", o_rst); end
        checks++; if (sclk_n != 2 * FRAME_STROBES) begin errors++; $display("FAIL stop_sclk_total: got %0d want %0d", sclk_n, 2 * FRAME_STROBES); end
        checks++; if (mclk_n != 2 * FRAME_STROBES * SCLK_DIV / MCLK_DIV) begin errors++; $display("FAIL stop_mclk_total: got %0d want %0d", mclk_n, 2 * FRAME_STROBES * SCLK_DIV / MCLK_DIV); end
        checks++; if (rise_cyc != last_sclk_cyc + 1) begin errors++; $display("FAIL stop_rst_align: rst at %0d want %0d", rise_cyc, last_sclk_cyc + 1); end
        repeat (20) tick();
        checks++; if (sclk_n != 2 * FRAME_STROBES || o_busy !== 1'b0) begin errors++; $display("FAIL stop_quiet: strobes %0d busy %b want %0d/0", sclk_n, o_busy, 2 * FRAME_STROBES); end
    endtask

    task automatic test_streaming();
        logic [47:0] word;
        for (int k = 0; k < 10; k++) feed0.push_back({24'(2 * k + 1), 24'(2 * k + 2)});
        start_run();
        repeat (3) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid: got %b want 1", out_valid); end
        for (int k = 0; k < 10; k++) pulse_ready($urandom_range(1, 4));
        checks++; if (got_q.size() != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 10; k++) begin
            word = {24'(2 * k + 1), 24'(2 * k + 2)};
            checks++;
            if (got_q[k] !== word || got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL stream_word%0d: got %h want %h", k, got_q[k], word);
            end
        end
        checks++; if (underrun_cnt !== '0) begin errors++; $display("FAIL stream_underrun: got %0d want 0", underrun_cnt); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_underrun();
        for (int h = 1; h >= 0; h--) begin
            cfg_hold_last = h[0];
            clear_cnt();
            feed0.push_back(W_UNDER);
            repeat (3) tick();
            pulse_ready(2);
            repeat (3) pulse_ready(1);
            checks++; if (got_q.size() != 4 || got_q[0] !== W_UNDER) begin errors++; $display("FAIL under_first_h%0d: got n=%0d want %h", h, got_q.size(), W_UNDER); end
            for (int k = 1; k < got_q.size(); k++) begin
                checks++;
                if (got_q[k] !== (h ? W_UNDER : 48'h0) || got_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL under_fill_h%0d_%0d: got %h want %h", h, k, got_q[k], h ? W_UNDER : 48'h0);
                end
            end
            checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL under_cnt_h%0d: got %0d want 3", h, underrun_cnt); end
            got_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_saturation();
        cfg_hold_last = 1'b0;
        clear_cnt();
        for (int k = 0; k < 20; k++) pulse_ready($urandom_range(0, 2));
        checks++; if (underrun_cnt !== 16'(mdl_under) || mdl_under != 20) begin errors++; $display("FAIL sat_wide_cnt: got %0d want 20", underrun_cnt); end
        checks++; if (s_underrun_cnt !== 4'd15) begin errors++; $display("FAIL sat_narrow_cnt: got %0d want 15", s_underrun_cnt); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_switch_mute();
        logic [47:0] w0, w0b, w1a, w1b;
        int b0, b1;
        w0 = rnd48(); w0b = rnd48(); w1a = rnd48(); w1b = rnd48();
        b0 = acc0_n; b1 = acc1_n; wrong_ready = 0;
        cfg_src = 1'b0; cfg_hold_last = 1'b0;
        feed0.push_back(w0); feed0.push_back(w0b);
        repeat (3) tick();
        cfg_src = 1'b1;
        feed1.push_back(w1a); feed1.push_back(w1b);
        repeat (2) tick();
        pulse_ready(3);
        checks++; if (got_q.size() < 1 || got_q[0] !== w0) begin errors++; $display("FAIL switch_held_first: got %h want %h", got_q.size() ? got_q[0] : 48'h0, w0); end
        checks++; if (acc1_n - b1 != 1 || acc0_n - b0 != 1) begin errors++; $display("FAIL switch_loads: src0 %0d src1 %0d want 1/1", acc0_n - b0, acc1_n - b1); end
        cfg_mute = 1'b1;
        pulse_ready(3);
        pulse_ready(3);
        checks++; if (got_q.size() != 3 || got_q[1] !== 48'h0 || got_q[2] !== 48'h0) begin errors++; $display("FAIL mute_zero: n=%0d last %h want 3 zeros", got_q.size(), got_q.size() ? got_q[got_q.size() - 1] : 48'h0); end
        checks++; if (feed1.size() != 0 || acc1_n - b1 != 2) begin errors++; $display("FAIL mute_consumed: src1 loads %0d want 2", acc1_n - b1); end
        cfg_mute = 1'b0; cfg_hold_last = 1'b1;
        pulse_ready(1);
        checks++; if (got_q.size() != 4 || got_q[3] !== w1b) begin errors++; $display("FAIL mute_last_kept: got %h want %h", got_q.size() == 4 ? got_q[3] : 48'h0, w1b); end
        for (int k = 0; k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL switch_model%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (wrong_ready != 0) begin errors++; $display("FAIL switch_ready_rules: %0d bad ready pulses want 0", wrong_ready); end
        feed0.delete();
        tick();
        cfg_src = 1'b0;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [47:0] x, y;
        x = rnd48(); y = rnd48();
        wrong_ready = 0;
        cfg_hold_last = 1'b1;
        feed0.push_back(x); feed0.push_back(y);
        repeat (4) tick();
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        repeat (3) tick();
        pulse_ready(2);
        checks++; if (got_q.size() != 3 || got_q[0] !== x || got_q[1] !== x || got_q[2] !== y) begin
            errors++; $display("FAIL b2b_sequence: n=%0d got %h,%h want %h,%h,%h", got_q.size(),
                got_q.size() > 1 ? got_q[1] : 48'h0, got_q.size() > 2 ? got_q[2] : 48'h0, x, x, y);
        end
        checks++; if (wrong_ready != 0) begin errors++; $display("FAIL b2b_blocked_load: %0d bad ready pulses want 0", wrong_ready); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_clear_collision();
        cfg_hold_last = 1'b0;
        clear_cnt();
        pulse_ready(1);
        pulse_ready(1);
        checks++; if (underrun_cnt !== 16'd2) begin errors++; $display("FAIL clr_pre: got %0d want 2", underrun_cnt); end
        out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        out_ready = 1'b0; cnt_clr = 1'b0;
        tick();
        checks++; if (underrun_cnt !== '0 || s_underrun_cnt !== '0) begin errors++; $display("FAIL clr_collision: got %0d/%0d want 0", underrun_cnt, s_underrun_cnt); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        pulse_ready(1);
        feed0.push_back(48'h5A5A5A_A5A5A5);
        repeat (3) tick();
        rst = 1'b1; cfg_enable = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (i2s_rst !== 1'b1 || busy !== 1'b0 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_run_state: i2s_rst %b busy %b state %0d want 1/0/IDLE", i2s_rst, busy, fsm_state); end
        checks++; if (mclk_en !== 1'b0 || sclk_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_strobes: %b%b%b want 000", mclk_en, sclk_en, out_valid); end
        checks++; if (out_data !== 48'h0 || underrun_cnt !== '0) begin errors++; $display("FAIL rst_run_data: out %h cnt %0d want 0/0", out_data, underrun_cnt); end
        checks++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin errors++; $display("FAIL rst_run_ready: %b%b want 00", src0_ready, src1_ready); end
        feed0.delete();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_divider();
        test_stop();
        test_streaming();
        test_underrun();
        test_saturation();
        test_switch_mute();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
